// File: rtl/uart_rx_mmio_pkg.sv
// Shared constants and types for the memory-mapped console UART receiver.
// Latency: n/a (declarations only). Backpressure: n/a.
// Contents: register offsets, status bit positions, receiver FSM state type, status word helper.
package uart_pkg;

  localparam logic [31:0] RX_DATA_OFS = 32'h0000_0000;
  localparam logic [31:0] RX_STAT_OFS = 32'h0000_0010;

  // Bit positions inside the status word
  localparam int STAT_TXRDY = 0;
  localparam int STAT_RXAV  = 1;
  localparam int STAT_OVR   = 2;
  localparam int STAT_FERR  = 3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  // TX ready is hard-wired to 1: the transmitter on this SoC never stalls the core.
  function automatic logic [31:0] status_word(input logic ferr, input logic ovr, input logic avail);
    logic [31:0] w;
    w = 32'h0;
    w[STAT_TXRDY] = 1'b1;
    w[STAT_RXAV]  = avail;
    w[STAT_OVR]   = ovr;
    w[STAT_FERR]  = ferr;
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_mmio_if.sv
// Data-memory bus slice seen by the UART receiver (request + registered read return).
// Latency: read data and hit flag appear the cycle after the request. Backpressure: none, always accepts.
// Signals: mem_valid/mem_write/mem_wmask/mem_wdata/mem_addr (request), mem_rdata/mem_rhit (response).
interface uart_rx_mmio_if;
  logic        mem_valid;
  logic        mem_write;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rhit;

  modport master (
    output mem_valid, mem_write, mem_wmask, mem_wdata, mem_addr,
    input  mem_rdata, mem_rhit
  );

  modport slave (
    input  mem_valid, mem_write, mem_wmask, mem_wdata, mem_addr,
    output mem_rdata, mem_rhit
  );
endinterface

// File: rtl/uart_rx_mmio_sync_fifo.sv
// Small synchronous FIFO holding received bytes until the core reads them.
// Latency: head is combinational from storage; a push is visible at head the cycle after. Backpressure: push ignored when full unless a pop happens in the same cycle.
// Ports: clk, rst (sync, active-high), push/din, pop, head, full, empty, count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int LOG2  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [LOG2:0]    count
);

  localparam int DEPTH = 1 << LOG2;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LOG2-1:0]  wr_ptr;
  logic [LOG2-1:0]  rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (LOG2+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // When full, a same-cycle pop frees the slot being written (wr_ptr == rd_ptr);
  // head is read before the edge, so the outgoing byte is not disturbed.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx_mmio.sv
// Memory-mapped 8N1 UART receiver: deserialises rx into a FIFO, exposes data/status registers on the data-memory bus.
// Latency: byte pushed at the stop-bit sample point (~9.5 bit times + 2 sync cycles after the start edge); bus reads return one cycle after the request.
// Backpressure: none on the bus; a byte arriving into a full FIFO (no same-cycle pop) is dropped and flagged as overrun.
// Ports: clk, rst (sync, active-high), rx (async serial in), bus (slave side of uart_rx_mmio_if), irq_rx (FIFO not empty, registered).
module uart_rx_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h7000_0000,
  parameter int          BAUD_DIV  = 16,
  parameter int          FIFO_LOG2 = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx,
  uart_rx_mmio_if.slave  bus,
  output logic           irq_rx
);

  localparam logic [15:0] CNT_HALF = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] CNT_FULL = 16'(BAUD_DIV - 1);

  // ---------------------------------------------------------------- synchroniser
  logic rx_m;
  logic rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // ---------------------------------------------------------------- receive FSM
  rx_state_e   state,  state_n;
  logic [15:0] cnt,    cnt_n;
  logic [2:0]  bitn,   bitn_n;
  logic [7:0]  shreg,  shreg_n;
  logic        push;
  logic        ferr_evt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      bitn  <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bitn  <= bitn_n;
      shreg <= shreg_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bitn_n   = bitn;
    shreg_n  = shreg;
    push     = 1'b0;
    ferr_evt = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = CNT_HALF;   // land the samples mid-bit
        end
      end
      START: begin
        if (cnt == '0) begin
          if (rx_s) begin
            state_n = IDLE;     // too short to be a start bit
          end else begin
            state_n = DATA;
            cnt_n   = CNT_FULL;
            bitn_n  = '0;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          shreg_n = {rx_s, shreg[7:1]};   // LSB arrives first
          cnt_n   = CNT_FULL;
          if (bitn == 3'd7) state_n = STOP;
          else              bitn_n  = bitn + 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      STOP: begin
        if (cnt == '0) begin
          if (rx_s) begin
            push    = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_evt = 1'b1;
            state_n  = BREAK;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      BREAK: begin
        // Line held low after a bad stop bit: do not mistake it for a new start.
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- FIFO
  logic [7:0]       fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FIFO_LOG2:0] fifo_count;
  logic             pop;

  sync_fifo #(
    .WIDTH (8),
    .LOG2  (FIFO_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (shreg),
    .pop   (pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ---------------------------------------------------------------- bus decode
  logic hit_data;
  logic hit_stat;
  logic rd_data;
  logic rd_stat;
  logic wr_stat;
  logic ovr_evt;
  logic overrun;
  logic frame_err;

  assign hit_data = bus.mem_valid && (bus.mem_addr == BASE_ADDR + RX_DATA_OFS);
  assign hit_stat = bus.mem_valid && (bus.mem_addr == BASE_ADDR + RX_STAT_OFS);
  assign rd_data  = hit_data && !bus.mem_write;
  assign rd_stat  = hit_stat && !bus.mem_write;
  assign wr_stat  = hit_stat &&  bus.mem_write && bus.mem_wmask[0];

  // Pop in the request cycle; the returned byte is the pre-pop head.
  assign pop      = rd_data && !fifo_empty;
  // A pop in the same cycle makes room, so full+pop+push is not an overrun.
  assign ovr_evt  = push && fifo_full && !pop;

  // Flag set wins over a same-cycle clear so no event is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (ovr_evt)
        overrun <= 1'b1;
      else if (rd_stat || (wr_stat && bus.mem_wdata[STAT_OVR]))
        overrun <= 1'b0;

      if (ferr_evt)
        frame_err <= 1'b1;
      else if (rd_stat || (wr_stat && bus.mem_wdata[STAT_FERR]))
        frame_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_rdata <= '0;
      bus.mem_rhit  <= 1'b0;
      irq_rx        <= 1'b0;
    end else begin
      if (rd_data)
        bus.mem_rdata <= fifo_empty ? 32'hFFFF_FFFF : {24'h0, fifo_head};
      else if (rd_stat)
        bus.mem_rdata <= status_word(frame_err, overrun, !fifo_empty);
      else
        bus.mem_rdata <= '0;
      bus.mem_rhit <= rd_data || rd_stat;
      irq_rx       <= (fifo_count != '0);
    end
  end

  // Write data bits and byte enables that carry no meaning for this block.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.mem_wdata[31:4], bus.mem_wdata[1:0], bus.mem_wmask[3:1]};

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed bench for uart_rx_mmio: serial frames on rx, register accesses checked against hand-computed values.
// Latency: reads sampled on the negedge after the request edge. Backpressure: n/a.
// Structure: table of bus vectors grouped by segment, plus hand-timed frame sequences for coincident pop/push and mid-frame reset.
module tb_uart_rx_mmio;
  import uart_pkg::*;

  localparam logic [31:0] BASE = 32'h7000_0000;
  localparam int          BAUD = 16;
  localparam logic [31:0] DATA_A = BASE + 32'h00;
  localparam logic [31:0] STAT_A = BASE + 32'h10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic irq_rx;

  int checks = 0;
  int errors = 0;

  uart_rx_mmio_if bus();

  uart_rx_mmio #(
    .BASE_ADDR (BASE),
    .BAUD_DIV  (BAUD),
    .FIFO_LOG2 (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx),
    .bus    (bus),
    .irq_rx (irq_rx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          seg;
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_rhit;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t rd(input int seg, input logic [31:0] addr, input logic [31:0] exp, input logic hit);
    vec_t v;
    v.seg = seg; v.addr = addr; v.wr = 1'b0; v.wmask = 4'h0; v.wdata = 32'h0;
    v.exp_rdata = exp; v.exp_rhit = hit;
    return v;
  endfunction

  function automatic vec_t wr(input int seg, input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
    vec_t v;
    v.seg = seg; v.addr = addr; v.wr = 1'b1; v.wmask = mask; v.wdata = data;
    v.exp_rdata = 32'h0; v.exp_rhit = 1'b0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_seg(input int seg);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].seg == seg) begin
        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_write = vecs[i].wr;
        bus.mem_wmask = vecs[i].wmask;
        bus.mem_wdata = vecs[i].wdata;
        bus.mem_addr  = vecs[i].addr;
        @(negedge clk);
        bus.mem_valid = 1'b0;
        bus.mem_write = 1'b0;
        check($sformatf("seg%0d_vec%0d_rdata", seg, i), bus.mem_rdata, vecs[i].exp_rdata);
        check($sformatf("seg%0d_vec%0d_rhit", seg, i), {31'h0, bus.mem_rhit}, {31'h0, vecs[i].exp_rhit});
      end
    end
  endtask

  // Drives one 8N1 frame cycle by cycle. Cycle c is driven on a negedge and
  // sampled by the posedge that follows. rd_cyc >= 0 issues a data-register
  // read on that cycle; rst_cyc >= 0 aborts the frame with a one-cycle reset.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int rd_cyc, input logic [31:0] rd_exp, input int rst_cyc);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int c = 0; c < 10 * BAUD; c++) begin
      @(negedge clk);
      if (rd_cyc >= 0 && c == rd_cyc + 1) begin
        check("coincident_read", bus.mem_rdata, rd_exp);
        bus.mem_valid = 1'b0;
      end
      if (c == rst_cyc) begin
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      rx = bits[c / BAUD];
      if (c == rd_cyc) begin
        bus.mem_valid = 1'b1;
        bus.mem_write = 1'b0;
        bus.mem_addr  = DATA_A;
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b1, -1, 32'h0, -1);
    idle(4);
  endtask

  initial begin
    bus.mem_valid = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_wmask = 4'h0;
    bus.mem_wdata = 32'h0;
    bus.mem_addr  = 32'h0;

    // seg0: reset state
    vecs.push_back(rd(0, STAT_A, 32'h1, 1'b1));
    // seg1: single byte 0x41, then non-matching accesses
    vecs.push_back(rd(1, STAT_A, 32'h3, 1'b1));
    vecs.push_back(rd(1, DATA_A, 32'h41, 1'b1));
    vecs.push_back(rd(1, STAT_A, 32'h1, 1'b1));
    vecs.push_back(rd(1, DATA_A, 32'hFFFF_FFFF, 1'b1));
    vecs.push_back(rd(1, BASE + 32'h4, 32'h0, 1'b0));
    vecs.push_back(rd(1, 32'h6000_0000, 32'h0, 1'b0));
    vecs.push_back(wr(1, DATA_A, 4'hF, 32'h99));
    vecs.push_back(rd(1, STAT_A, 32'h1, 1'b1));
    // seg2: after glitch
    vecs.push_back(rd(2, STAT_A, 32'h1, 1'b1));
    // seg3: byte after glitch
    vecs.push_back(rd(3, DATA_A, 32'h5A, 1'b1));
    vecs.push_back(rd(3, STAT_A, 32'h1, 1'b1));
    // seg4: five bytes into a four-entry FIFO
    vecs.push_back(rd(4, STAT_A, 32'h7, 1'b1));
    vecs.push_back(rd(4, DATA_A, 32'h01, 1'b1));
    vecs.push_back(rd(4, DATA_A, 32'h02, 1'b1));
    vecs.push_back(rd(4, DATA_A, 32'h03, 1'b1));
    vecs.push_back(rd(4, DATA_A, 32'h04, 1'b1));
    vecs.push_back(rd(4, DATA_A, 32'hFFFF_FFFF, 1'b1));
    vecs.push_back(rd(4, STAT_A, 32'h1, 1'b1));
    // seg5: framing error, writes that must not clear it
    vecs.push_back(wr(5, STAT_A, 4'h0, 32'h8));
    vecs.push_back(wr(5, STAT_A, 4'h1, 32'h4));
    vecs.push_back(rd(5, STAT_A, 32'h9, 1'b1));
    vecs.push_back(rd(5, DATA_A, 32'hFFFF_FFFF, 1'b1));
    vecs.push_back(rd(5, STAT_A, 32'h1, 1'b1));
    // seg6: framing error cleared by write
    vecs.push_back(wr(6, STAT_A, 4'h1, 32'h8));
    vecs.push_back(rd(6, STAT_A, 32'h1, 1'b1));
    // seg7: frame after break
    vecs.push_back(rd(7, DATA_A, 32'hAA, 1'b1));
    // seg8: after coincident pop/push
    vecs.push_back(rd(8, STAT_A, 32'h3, 1'b1));
    vecs.push_back(rd(8, DATA_A, 32'h11, 1'b1));
    vecs.push_back(rd(8, DATA_A, 32'h12, 1'b1));
    vecs.push_back(rd(8, DATA_A, 32'h13, 1'b1));
    vecs.push_back(rd(8, DATA_A, 32'h14, 1'b1));
    vecs.push_back(rd(8, DATA_A, 32'hFFFF_FFFF, 1'b1));
    // seg9: after mid-frame reset
    vecs.push_back(rd(9, STAT_A, 32'h1, 1'b1));
    vecs.push_back(rd(9, DATA_A, 32'hFFFF_FFFF, 1'b1));
    // seg10: clean frame after reset
    vecs.push_back(rd(10, DATA_A, 32'h3C, 1'b1));
    vecs.push_back(rd(10, STAT_A, 32'h1, 1'b1));

    // Reset
    idle(3);
    rst = 1'b0;
    idle(1);
    check("reset_rdata", bus.mem_rdata, 32'h0);
    check("reset_rhit", {31'h0, bus.mem_rhit}, 32'h0);
    check("reset_irq", {31'h0, irq_rx}, 32'h0);
    apply_seg(0);

    // Single byte
    send(8'h41);
    check("irq_after_byte", {31'h0, irq_rx}, 32'h1);
    apply_seg(1);
    check("irq_after_drain", {31'h0, irq_rx}, 32'h0);

    // Short low pulse: rejected as a glitch
    @(negedge clk);
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(30);
    check("glitch_irq", {31'h0, irq_rx}, 32'h0);
    apply_seg(2);
    send(8'h5A);
    apply_seg(3);

    // Overrun
    for (int i = 1; i <= 5; i++) send(8'(i));
    apply_seg(4);

    // Bad stop bit followed by a long break
    send_frame(8'h55, 1'b0, -1, 32'h0, -1);
    idle(40);
    rx = 1'b1;
    idle(10);
    apply_seg(5);
    send_frame(8'h00, 1'b0, -1, 32'h0, -1);
    idle(20);
    rx = 1'b1;
    idle(10);
    apply_seg(6);
    send(8'hAA);
    apply_seg(7);

    // Fill, then read exactly as the fifth byte is pushed (stop sample at cycle 154)
    for (int i = 0; i < 4; i++) send(8'h10 + 8'(i));
    send_frame(8'h14, 1'b1, 154, 32'h10, -1);
    idle(4);
    apply_seg(8);

    // Reset during data bit 4 of 0xC3 with one byte already queued
    send(8'h77);
    check("irq_before_reset", {31'h0, irq_rx}, 32'h1);
    send_frame(8'hC3, 1'b1, -1, 32'h0, 5 * BAUD + 5);
    check("midreset_rdata", bus.mem_rdata, 32'h0);
    check("midreset_rhit", {31'h0, bus.mem_rhit}, 32'h0);
    check("midreset_irq", {31'h0, irq_rx}, 32'h0);
    idle(20);
    apply_seg(9);
    send(8'h3C);
    apply_seg(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
